// File: rtl/uart_pkg.sv
// Shared UART constants and FSM encodings.
// Used by uart_rx and the future uart_tx.
package uart_pkg;

   localparam int OVERSAMPLE    = 16;
   localparam int DATA_BITS_DEF = 8;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_START = 2'd1;
   localparam state_t ST_DATA  = 2'd2;
   localparam state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: line inputs plus byte output strobes.
// The slave side is the receiver; master is the line/consumer side.
interface uart_rx_if #(
   parameter int DATA_BITS = 8
);

   logic                 baud;
   logic                 rx;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 frame_err;
   logic                 busy;

   modport master (
      output baud, rx,
      input  data_out, data_valid, frame_err, busy
   );

   modport slave (
      input  baud, rx,
      output data_out, data_valid, frame_err, busy
   );

endinterface

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer.
// RST_VAL sets the value both flops take in reset.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] ff_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff_q <= {2{RST_VAL}};
      end else begin
         ff_q <= {ff_q[0], d_i};
      end
   end

   assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver on a 16x oversample baud strobe.
// Delivers good bytes as a one-cycle pulse, flags bad stop bits.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = uart_pkg::DATA_BITS_DEF,
   parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
   input logic        clk,
   input logic        rst_n,
   uart_rx_if.slave   bus
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);

   localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BLST = BW'(DATA_BITS - 1);

   logic rx_s;
   logic baud_q;
   logic tick;

   state_t               state_q, state_d;
   logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;

   sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (bus.rx),
      .q_o   (rx_s)
   );

   assign tick = bus.baud & ~baud_q;

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      ferr_d     = 1'b0;
      if (tick) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!rx_s) begin
                  state_d    = ST_START;
                  tick_cnt_d = '0;
               end
            end
            ST_START: begin
               if (tick_cnt_q == MID) begin
                  tick_cnt_d = '0;
                  bit_cnt_d  = '0;
                  state_d    = rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
            ST_DATA: begin
               if (tick_cnt_q == LAST) begin
                  shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                  tick_cnt_d = '0;
                  if (bit_cnt_q == BLST) begin
                     state_d = ST_STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
            ST_STOP: begin
               // Leaving at mid stop bit gives half a bit to catch the next start.
               if (tick_cnt_q == LAST) begin
                  tick_cnt_d = '0;
                  state_d    = ST_IDLE;
                  if (rx_s) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     ferr_d = 1'b1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_q     <= 1'b0;
         state_q    <= ST_IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         baud_q     <= bus.baud;
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
      end
   end

   assign bus.data_out   = data_q;
   assign bus.data_valid = valid_q;
   assign bus.frame_err  = ferr_q;
   assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table frames, hand-written corner cases,
// and random frames checked against an event-queue model.
module tb_uart_rx;

   localparam int BITP = 64;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         bitp;
      int         gap;
      logic       exp_valid;
      logic       exp_err;
   } vec_t;

   typedef struct {
      logic       err;
      logic [7:0] data;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned bcnt = 0;
   int          checks = 0;
   int          errors = 0;
   int          busy_cnt = 0;
   logic [7:0]  last_good = 8'h00;
   ev_t         exp_q[$];
   ev_t         mon_e;
   vec_t        tbl[7];

   uart_rx_if #(.DATA_BITS(8)) bus ();

   uart_rx #(
      .DATA_BITS  (8),
      .OVERSAMPLE (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // baud: square wave, 4 clk period, changed away from the active edge
   always @(negedge clk) begin
      bcnt     = bcnt + 1;
      bus.baud = bcnt[1];
   end

   function automatic void chk(string name, logic [31:0] act,
                               logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic void push_exp(logic err, logic [7:0] d);
      ev_t e;
      e.err  = err;
      e.data = d;
      exp_q.push_back(e);
      if (!err) last_good = d;
   endfunction

   // Every pulse must match the head of the expected-event queue.
   always @(negedge clk) begin
      if (bus.busy) busy_cnt = busy_cnt + 1;
      if (bus.data_valid || bus.frame_err) begin
         chk("pulse_exclusive",
             32'(bus.data_valid & bus.frame_err), 32'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse",
                {30'd0, bus.data_valid, bus.frame_err}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("pulse_kind", 32'(bus.frame_err), 32'(mon_e.err));
            if (!mon_e.err) begin
               chk("rx_data", 32'(bus.data_out), 32'(mon_e.data));
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop,
                             input int bitp);
      bus.rx = 1'b0;
      idle(bitp);
      for (int i = 0; i < 8; i++) begin
         bus.rx = d[i];
         idle(bitp);
      end
      bus.rx = stop;
      idle(bitp);
      bus.rx = 1'b1;
   endtask

   initial begin
      logic [7:0] rd;
      logic       rs;

      tbl[0] = '{8'h11, 1'b1, BITP, 64, 1'b1, 1'b0};
      tbl[1] = '{8'h3C, 1'b0, BITP, 64, 1'b0, 1'b1};
      tbl[2] = '{8'h00, 1'b1, BITP, 0,  1'b1, 1'b0};
      tbl[3] = '{8'hFF, 1'b1, BITP, 0,  1'b1, 1'b0};
      tbl[4] = '{8'h55, 1'b1, BITP, 64, 1'b1, 1'b0};
      tbl[5] = '{8'hC3, 1'b1, 66,   64, 1'b1, 1'b0};
      tbl[6] = '{8'hC3, 1'b1, 62,   64, 1'b1, 1'b0};

      bus.rx = 1'b1;
      rst_n  = 1'b0;
      idle(5);
      chk("reset_data_out", 32'(bus.data_out), 32'h00);
      chk("reset_valid", 32'(bus.data_valid), 32'd0);
      chk("reset_ferr", 32'(bus.frame_err), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      rst_n = 1'b1;
      idle(100);

      // nominal frame: busy spans 152 ticks of 4 clk
      busy_cnt = 0;
      push_exp(1'b0, 8'hA5);
      send_frame(8'hA5, 1'b1, BITP);
      chk("nominal_pending", 32'(exp_q.size()), 32'd0);
      idle(64);
      chk("nominal_busy_cycles", 32'(busy_cnt), 32'd608);
      chk("nominal_data_out", 32'(bus.data_out), 32'hA5);

      for (int i = 0; i < 7; i++) begin
         if (tbl[i].exp_valid || tbl[i].exp_err) begin
            push_exp(tbl[i].exp_err, tbl[i].data);
         end
         send_frame(tbl[i].data, tbl[i].stop, tbl[i].bitp);
         chk("table_pending", 32'(exp_q.size()), 32'd0);
         idle(tbl[i].gap);
         chk("table_data_out", 32'(bus.data_out), 32'(last_good));
      end

      // false start: 4 ticks low, rejected at the 8th tick
      busy_cnt = 0;
      bus.rx = 1'b0;
      idle(16);
      bus.rx = 1'b1;
      idle(64);
      chk("false_start_busy_cycles", 32'(busy_cnt), 32'd32);
      chk("false_start_idle", 32'(bus.busy), 32'd0);
      chk("false_start_data_out", 32'(bus.data_out), 32'(last_good));

      // reset during data bit 3 of 0x7E
      fork
         send_frame(8'h7E, 1'b1, BITP);
         begin
            idle(4 * BITP + 32);
            rst_n = 1'b0;
            #1;
            chk("midreset_data_out", 32'(bus.data_out), 32'h00);
            chk("midreset_valid", 32'(bus.data_valid), 32'd0);
            chk("midreset_ferr", 32'(bus.frame_err), 32'd0);
            chk("midreset_busy", 32'(bus.busy), 32'd0);
         end
      join
      last_good = 8'h00;
      idle(10);
      rst_n = 1'b1;
      idle(64);
      push_exp(1'b0, 8'h5A);
      send_frame(8'h5A, 1'b1, BITP);
      chk("post_reset_pending", 32'(exp_q.size()), 32'd0);
      idle(64);
      chk("post_reset_data_out", 32'(bus.data_out), 32'h5A);

      for (int i = 0; i < 20; i++) begin
         rd = 8'($urandom);
         rs = ($urandom_range(0, 3) != 0);
         push_exp(!rs, rd);
         send_frame(rd, rs, BITP);
         chk("rand_pending", 32'(exp_q.size()), 32'd0);
         idle(rs ? $urandom_range(0, 80) : $urandom_range(64, 128));
         chk("rand_data_out", 32'(bus.data_out), 32'(last_good));
      end

      idle(100);
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("final_idle", 32'(bus.busy), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART path. It consumes the 16x-oversample `baud` square wave produced by `baudrate_gen` and the asynchronous `rx` line. It recovers 8N1 frames (LSB first) and presents each byte as a one-cycle `data_valid` pulse to the downstream terminal/display logic. Framing errors are flagged, not delivered.

## Interface
- `DATA_BITS`, default 8: data bits per frame; 5..8 legal.
- `OVERSAMPLE`, default 16: `baud` rising edges per bit period. It must match the 16x factor used by `baudrate_gen`.
- `clk`  in  1  system clock. Same clock as `baudrate_gen`.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `baud`  in  1  16x-oversample square wave from `baudrate_gen`. Only its rising edge is used.
- `rx`  in  1  serial line, asynchronous, idle high.
- `data_out`  out  DATA_BITS  last good byte. Holds until the next good frame.
- `data_valid`  out  1  one-cycle pulse when `data_out` is updated.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples low.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- **Input conditioning**
  - `rx` passes through a 2-FF synchronizer to give `rx_s`. Its reset value is 1.
  - `baud` is registered into `baud_q` (reset 0).
  - `tick = baud & ~baud_q`. All state advances happen only on clock edges where `tick = 1`.
- **Counters**
  - `tick_cnt` is $clog2(OVERSAMPLE) bits wide.
  - `bit_cnt` is $clog2(DATA_BITS) bits wide.
  - Both wrap only by explicit clear. No arithmetic overflow is relied on.
- **IDLE**
  - On a tick with `rx_s == 0`: go to START and clear `tick_cnt`.
- **START**
  - On each tick: `tick_cnt++`.
  - On the tick where `tick_cnt == OVERSAMPLE/2-1` (mid start bit):
    - If `rx_s == 0`: go to DATA and clear `tick_cnt` and `bit_cnt`.
    - Otherwise it is a false start: go back to IDLE. No outputs change.
- **DATA**
  - On each tick: `tick_cnt++`.
  - At `tick_cnt == OVERSAMPLE-1`:
    - Shift `rx_s` into the MSB of the shift register (LSB-first reception) and clear `tick_cnt`.
    - If `bit_cnt == DATA_BITS-1`, go to STOP. Otherwise `bit_cnt++`.
- **STOP**
  - At `tick_cnt == OVERSAMPLE-1` (mid stop bit):
    - If `rx_s == 1`: load `data_out` from the shift register and pulse `data_valid`.
    - Otherwise: pulse `frame_err`. `data_out` is unchanged.
  - Return to IDLE in both cases.
  - Returning at mid stop bit leaves half a bit of margin to resync on the next start edge.
- **Break (line held low)**
  - Every frame time produces one `frame_err` pulse. No `data_valid` is asserted.
- **Reset**
  - Asserting `rst_n` mid-frame aborts immediately: state goes to IDLE and all counters and outputs go to 0 (`rx_s` goes to 1).
  - No partial byte is ever delivered.
- **`baud` stalled**
  - With no ticks, the FSM holds its state indefinitely. No timeout exists.

## Timing
- **Reset values:** `data_out = 0`, `data_valid = 0`, `frame_err = 0`, `busy = 0`, state = IDLE.
- **Registered outputs:** all outputs are registered.
  - `data_valid` and `frame_err` are high for exactly one `clk` cycle, in the cycle after the stop-sample tick edge.
  - They are never asserted together.
- **`busy`**
  - Rises in the cycle after the start-detect tick.
  - Falls together with the `data_valid`/`frame_err` pulse, or on false-start rejection.
- **Latency**
  - From the `rx` falling edge to start detection: ≤ 2 `clk` cycles of synchronizer plus ≤ 1 tick.
  - From start detection to `data_valid`: (1 + DATA_BITS + 1) bit periods − OVERSAMPLE/2 ticks, +1 `clk` cycle.
- **Sampling point:** every sample is taken 8 ticks (±1 tick of detection jitter) after the bit edge. This tolerates about ±4% baud mismatch across a 10-bit frame.
- **Throughput:** back-to-back frames with no idle gap must be received without loss.

## Structure
- **Shared `uart_pkg`:** holds `OVERSAMPLE` (16), the FSM state encodings (IDLE, START, DATA, STOP; 2 bits) and the default `DATA_BITS`. The package is shared with the future `uart_tx`.
- **Sub-module `sync_2ff`:** a generic 1-bit two-flop synchronizer with a reset-value parameter. It is reused for all asynchronous inputs.
- **Remaining logic:** the FSM, counters and shift register stay in `uart_rx`.

## Test plan
The bench drives `baud` directly as a square wave with period 4 `clk` cycles, giving 64 `clk` cycles per bit.
- **Nominal frame:** send 8N1 frame 0xA5 → exactly one `data_valid` pulse, `data_out = 0xA5`, `frame_err` stays 0, `busy` high for ~9.5 bit periods.
- **False start:** pull `rx` low for 4 ticks, then high → no `data_valid` or `frame_err`, `busy` returns to 0 at tick 8, and the FSM is in IDLE.
- **Framing error:** send 0x3C with stop bit 0, after a good 0x11 → one `frame_err` pulse, no `data_valid`, `data_out` still 0x11.
- **Back-to-back:** send 0x00, 0xFF, 0x55 with no idle gap → three `data_valid` pulses with values in order and no errors.
- **Reset mid-frame:** assert `rst_n` low during data bit 3 of 0x7E → all outputs 0 immediately. After release, a full 0x5A frame is received correctly.
- **Baud mismatch:** send 0xC3 with the bit period stretched +3%, then shrunk −3% → `data_out = 0xC3` both times.
